// File: rtl/lb_reg_bank.sv
// Localbus register bank: eight read/write config words, eight read-only status words,
// and a fixed-latency read-return pipeline with no stall.
module lb_reg_bank #(
   parameter int unsigned n_lat     = 8,
   parameter logic [23:0] base_addr = 24'h020000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [23:0]  addr,
   input  logic         control_strobe,
   input  logic         control_rd,
   input  logic [31:0]  data_out,
   output logic [31:0]  data_in,
   output logic         rd_valid,
   output logic [255:0] cfg_bus,
   input  logic [255:0] status_bus,
   output logic [7:0]   wr_pulse,
   output logic         stop_sim
);

   // The output register is the last of the n_lat stages.
   localparam int n_stg = int'(n_lat) - 1;

   logic [7:0][31:0]       cfg_q, cfg_d;
   logic [7:0]             wr_pulse_q, wr_pulse_d;
   logic [n_stg-1:0]       ld_q, ld_d;
   logic [n_stg-1:0]       vld_q, vld_d;
   logic [n_stg-1:0][31:0] dat_q, dat_d;
   logic [31:0]            data_in_q, data_in_d;
   logic                   rd_valid_q, rd_valid_d;

   logic [7:0][31:0]       status_s;
   logic                   hit_s;
   logic                   sel_s;
   logic [2:0]             idx_s;
   logic                   unused_addr3_s;

   assign status_s       = status_bus;
   assign hit_s          = control_strobe & (addr[23:5] == base_addr[23:5]);
   assign sel_s          = addr[4];
   assign idx_s          = addr[2:0];
   assign unused_addr3_s = addr[3];

   // Config write decode and the matching one-cycle write pulse
   always_comb begin
      cfg_d      = cfg_q;
      wr_pulse_d = 8'h00;
      if (hit_s && !control_rd && !sel_s) begin
         cfg_d[idx_s]      = data_out;
         wr_pulse_d[idx_s] = 1'b1;
      end else begin
         cfg_d      = cfg_q;
         wr_pulse_d = 8'h00;
      end
   end

   // Read pipeline; any read strobe reloads data_in on return, only hits flag rd_valid
   always_comb begin
      ld_d       = '0;
      vld_d      = '0;
      dat_d      = '0;
      ld_d[0]    = control_strobe & control_rd;
      vld_d[0]   = hit_s & control_rd;
      if (hit_s && control_rd) begin
         if (sel_s) begin
            dat_d[0] = status_s[idx_s];
         end else begin
            dat_d[0] = cfg_q[idx_s];
         end
      end else begin
         dat_d[0] = 32'h0000_0000;
      end
      for (int i = 1; i < n_stg; i++) begin
         ld_d[i]  = ld_q[i-1];
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
      rd_valid_d = vld_q[n_stg-1];
      if (ld_q[n_stg-1]) begin
         data_in_d = dat_q[n_stg-1];
      end else begin
         data_in_d = data_in_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q      <= '0;
         wr_pulse_q <= 8'h00;
         ld_q       <= '0;
         vld_q      <= '0;
         dat_q      <= '0;
         data_in_q  <= 32'h0000_0000;
         rd_valid_q <= 1'b0;
      end else begin
         cfg_q      <= cfg_d;
         wr_pulse_q <= wr_pulse_d;
         ld_q       <= ld_d;
         vld_q      <= vld_d;
         dat_q      <= dat_d;
         data_in_q  <= data_in_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign cfg_bus  = cfg_q;
   assign wr_pulse = wr_pulse_q;
   assign data_in  = data_in_q;
   assign rd_valid = rd_valid_q;
   assign stop_sim = cfg_q[7][0];

endmodule

// File: tb/tb_lb_reg_bank.sv
// Directed bench for lb_reg_bank at n_lat = 2, 8 and 15 driven from shared stimulus;
// read returns are checked cycle by cycle against a hand-built expected timeline.
module tb_lb_reg_bank;

   localparam logic [23:0] BASE = 24'h020000;
   localparam int NK = 3;
   localparam int LAT [NK] = '{2, 8, 15};
   localparam int NC = 256;

   logic         clk = 1'b0;
   logic         rst;
   logic [23:0]  addr;
   logic         control_strobe;
   logic         control_rd;
   logic [31:0]  data_out;
   logic [255:0] status_bus;

   logic [31:0]  din  [NK];
   logic         rv   [NK];
   logic [255:0] cfgb [NK];
   logic [7:0]   wrp  [NK];
   logic         ss   [NK];

   always #5 clk = ~clk;

   lb_reg_bank #(.n_lat(2), .base_addr(24'h020013)) u_l2 (
      .clk(clk), .rst(rst), .addr(addr), .control_strobe(control_strobe),
      .control_rd(control_rd), .data_out(data_out), .data_in(din[0]), .rd_valid(rv[0]),
      .cfg_bus(cfgb[0]), .status_bus(status_bus), .wr_pulse(wrp[0]), .stop_sim(ss[0]));

   lb_reg_bank u_l8 (
      .clk(clk), .rst(rst), .addr(addr), .control_strobe(control_strobe),
      .control_rd(control_rd), .data_out(data_out), .data_in(din[1]), .rd_valid(rv[1]),
      .cfg_bus(cfgb[1]), .status_bus(status_bus), .wr_pulse(wrp[1]), .stop_sim(ss[1]));

   lb_reg_bank #(.n_lat(15)) u_l15 (
      .clk(clk), .rst(rst), .addr(addr), .control_strobe(control_strobe),
      .control_rd(control_rd), .data_out(data_out), .data_in(din[2]), .rd_valid(rv[2]),
      .cfg_bus(cfgb[2]), .status_bus(status_bus), .wr_pulse(wrp[2]), .stop_sim(ss[2]));

   int cyc = 0;
   int n_chk = 0;
   int n_bad = 0;

   logic [31:0] hd   [NK][NC];
   logic        hv   [NK][NC];
   bit          upd  [NK][NC];
   logic [31:0] uval [NK][NC];
   bit          uvld [NK][NC];
   bit          clr  [NC];
   logic [255:0] ecfg;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < NC) begin
         for (int k = 0; k < NK; k++) begin
            hd[k][cyc] = din[k];
            hv[k][cyc] = rv[k];
         end
      end
   end

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic strobe(input logic rd, input logic [23:0] a, input logic [31:0] d, output int s);
      control_strobe = 1'b1;
      control_rd     = rd;
      addr           = a;
      data_out       = d;
      s              = cyc;
      @(negedge clk);
      control_strobe = 1'b0;
      control_rd     = 1'b0;
   endtask

   task automatic exp_rd(input int s, input logic [31:0] d, input bit hit);
      for (int k = 0; k < NK; k++) begin
         if (s + LAT[k] < NC) begin
            upd[k][s+LAT[k]]  = 1'b1;
            uval[k][s+LAT[k]] = hit ? d : 32'h0;
            uvld[k][s+LAT[k]] = hit;
         end
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] wrp_e, input logic [255:0] cfg_e,
                          input logic ss_e);
      for (int k = 0; k < NK; k++) begin
         check_val($sformatf("%s_wrp_l%0d", tag, LAT[k]), 256'(wrp[k]), 256'(wrp_e));
         check_val($sformatf("%s_cfg_l%0d", tag, LAT[k]), cfgb[k], cfg_e);
         check_val($sformatf("%s_stop_l%0d", tag, LAT[k]), 256'(ss[k]), 256'(ss_e));
      end
   endtask

   task automatic chk_rdout_zero(input string tag);
      for (int k = 0; k < NK; k++) begin
         check_val($sformatf("%s_din_l%0d", tag, LAT[k]), 256'(din[k]), 256'(32'h0));
         check_val($sformatf("%s_rv_l%0d", tag, LAT[k]), 256'(rv[k]), 256'(1'b0));
      end
   endtask

   initial begin
      int s;
      int r0;
      int last;
      logic [31:0] cur;

      rst            = 1'b1;
      addr           = 24'h000000;
      control_strobe = 1'b0;
      control_rd     = 1'b0;
      data_out       = 32'h0;
      status_bus     = '0;
      ecfg           = '0;

      // Reset sampled at edges 1..3
      clr[1] = 1'b1; clr[2] = 1'b1; clr[3] = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_all("reset", 8'h00, ecfg, 1'b0);
      chk_rdout_zero("reset");

      // Write then read-back in the wr_pulse cycle
      strobe(1'b0, BASE + 24'h2, 32'hDEADBEEF, s);
      ecfg[95:64] = 32'hDEADBEEF;
      chk_all("wr2", 8'h04, ecfg, 1'b0);
      strobe(1'b1, BASE + 24'h2, 32'h0, s);
      exp_rd(s, 32'hDEADBEEF, 1'b1);
      chk_all("wr2_end", 8'h00, ecfg, 1'b0);

      // Status sampled only at the strobe cycle
      status_bus[191:160] = 32'h12345678;
      strobe(1'b1, BASE + 24'h15, 32'h0, s);
      status_bus[191:160] = 32'h0;
      exp_rd(s, 32'h12345678, 1'b1);

      // Preload cfg i = i+1, then eight back-to-back reads (odd ones via the addr[3] alias)
      for (int i = 0; i < 8; i++) begin
         strobe(1'b0, BASE + 24'(i), 32'(i + 1), s);
         ecfg[32*i +: 32] = 32'(i + 1);
      end
      chk_all("preload", 8'h80, ecfg, 1'b0);
      for (int i = 0; i < 8; i++) begin
         strobe(1'b1, BASE + 24'(i + 8 * (i % 2)), 32'h0, s);
         exp_rd(s, 32'(i + 1), 1'b1);
      end

      // Miss read, sel=1 write, and a write to another block
      strobe(1'b1, 24'h000000, 32'h0, s);
      exp_rd(s, 32'h0, 1'b0);
      strobe(1'b0, BASE + 24'h11, 32'hFFFFFFFF, s);
      chk_all("sel1wr", 8'h00, ecfg, 1'b0);
      strobe(1'b0, 24'h030003, 32'hAAAAAAAA, s);
      chk_all("misswr", 8'h00, ecfg, 1'b0);

      repeat (16) @(negedge clk);

      // stop_sim, then reset with a read in flight and a strobe during reset
      strobe(1'b0, BASE + 24'h7, 32'h1, s);
      ecfg[255:224] = 32'h1;
      chk_all("stop", 8'h80, ecfg, 1'b1);
      strobe(1'b1, BASE + 24'h0, 32'h0, s);
      rst = 1'b1;
      r0  = cyc;
      clr[r0+1] = 1'b1;
      clr[r0+2] = 1'b1;
      strobe(1'b0, BASE + 24'h3, 32'h55, s);
      @(negedge clk);
      ecfg = '0;
      chk_all("rst2", 8'h00, ecfg, 1'b0);
      chk_rdout_zero("rst2");

      // First strobe after reset release is honoured
      rst = 1'b0;
      strobe(1'b0, BASE + 24'h1, 32'h77, s);
      ecfg[63:32] = 32'h77;
      chk_all("post", 8'h02, ecfg, 1'b0);
      strobe(1'b1, BASE + 24'h1, 32'h0, s);
      exp_rd(s, 32'h77, 1'b1);

      repeat (20) @(negedge clk);

      // Walk the recorded outputs against the expected return timeline
      last = (cyc < NC) ? cyc : NC;
      for (int k = 0; k < NK; k++) begin
         cur = 32'h0;
         for (int c = 1; c < last; c++) begin
            if (clr[c]) begin
               cur = 32'h0;
            end else if (upd[k][c]) begin
               cur = uval[k][c];
            end
            check_val($sformatf("din_l%0d_c%0d", LAT[k], c), 256'(hd[k][c]), 256'(cur));
            check_val($sformatf("rv_l%0d_c%0d", LAT[k], c), 256'(hv[k][c]),
                      256'(upd[k][c] && uvld[k][c] && !clr[c]));
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/lb_reg_bank.md
LB_REG_BANK -- requirements
Module: lb_reg_bank

Interface
REQ-001 The block SHALL have parameter n_lat, default 8, legal range 2..15: cycles from a read strobe to its read data on data_in.
REQ-002 The block SHALL have parameter base_addr, default 24'h020000: address[23:5] match value; bits [4:0] of base_addr are ignored.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port addr, input, 24 bits: localbus address, qualified by control_strobe.
REQ-006 The block SHALL have port control_strobe, input, 1 bit: one-cycle transaction qualifier.
REQ-007 The block SHALL have port control_rd, input, 1 bit: 1 = read, 0 = write, sampled with control_strobe.
REQ-008 The block SHALL have port data_out, input, 32 bits: write data from the localbus master.
REQ-009 The block SHALL have port data_in, output, 32 bits: read data returned to the localbus master.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: one-cycle marker for a read-data return by this block.
REQ-011 The block SHALL have port cfg_bus, output, 256 bits: eight 32-bit config registers; register i occupies bits [32i+31:32i].
REQ-012 The block SHALL have port status_bus, input, 256 bits: eight 32-bit read-only status words, same packing as cfg_bus.
REQ-013 The block SHALL have port wr_pulse, output, 8 bits: one-cycle pulse per config register written.
REQ-014 The block SHALL have port stop_sim, output, 1 bit: level equal to cfg register 7 bit 0.

Function
REQ-015 A hit SHALL be control_strobe=1 with addr[23:5]==base_addr[23:5]; sel=addr[4], idx=addr[2:0]; addr[3] ignored (aliases).
REQ-016 A write hit with sel=0 SHALL load data_out into cfg register idx at the next clock edge and assert wr_pulse[idx] for exactly that one following cycle.
REQ-017 Writes with sel=1, and all non-hit strobes, SHALL change no state and produce no pulse.
REQ-018 Read data for a read hit SHALL be captured at the strobe cycle (cfg[idx] if sel=0, status_bus word idx if sel=1) and carried through an n_lat-deep pipeline.
REQ-019 Read data SHALL appear on data_in with rd_valid=1 exactly n_lat cycles after the strobe cycle (strobe at cycle T -> valid at T+n_lat).
REQ-020 data_in SHALL hold its last returned value until the next return; a non-hit read SHALL return 32'h0 at T+n_lat with rd_valid=0.
REQ-021 The pipeline SHALL accept one strobe per cycle with no stall; back-to-back reads return in order on consecutive cycles.
REQ-022 A read hit of cfg[i] issued the cycle after a write to cfg[i] SHALL return the new value; a read in the same cycle as a wr_pulse returns the post-write value.
REQ-023 Status words SHALL be sampled only at the strobe cycle; later status_bus changes SHALL not alter in-flight data.
REQ-024 Implementation size target: 120-400 lines; no combinational path from inputs to data_in or rd_valid.

Reset
REQ-025 While rst=1 at a clock edge: all cfg registers SHALL become 0, wr_pulse=0, rd_valid=0, data_in=0, stop_sim=0, and all read-pipeline stages cleared.
REQ-026 Strobes coincident with rst=1 SHALL be ignored; reads in flight when rst asserts SHALL never produce rd_valid.
REQ-027 The first strobe accepted on the cycle after rst deasserts SHALL be processed normally.

Verification
REQ-028 Write 32'hDEADBEEF to base+2, then read base+2 next cycle -> wr_pulse=8'h04 for one cycle; data_in=32'hDEADBEEF with rd_valid=1 exactly n_lat cycles after the read strobe.
REQ-029 Set status_bus word 5 = 32'h12345678, read base+0x15, change word 5 to 0 the next cycle -> return 32'h12345678 at T+n_lat.
REQ-030 Eight consecutive-cycle reads of cfg 0..7 preloaded with i+1 -> returns 1..8 on eight consecutive cycles, rd_valid high for all eight.
REQ-031 Read 24'h000000 (miss) and write base+0x11 -> data_in=0, rd_valid=0 at T+n_lat, cfg_bus unchanged, wr_pulse stays 0.
REQ-032 Write 1 to base+7 -> stop_sim=1 the next cycle; assert rst with a read outstanding -> stop_sim=0, cfg_bus=0, no rd_valid ever for that read.
REQ-033 Run REQ-028 through REQ-032 at n_lat=2 and n_lat=15 -> latency matches the parameter exactly.
